alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised successor to the combinational ALU control decoder: decodes ALUop/funct
//  and executes the operation itself behind valid/ready handshakes. Single-cycle ops
//  (add/sub/logic/slt/shift) complete in one cycle. MULTU runs as an iterative shift-add.
//  Sits in the EX stage, between the operand muxes and the EX/MEM register.
// PARAMETERS
//  WIDTH   32  operand/result width; power of 2, >=8; shift amount width SW = $clog2(WIDTH)
//  MUL_EN  1   1: MULTU supported; 0: funct 011001 decodes as illegal
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      request valid
//  in_ready   out  1      unit can accept a request
//  alu_op     in   2      00 add (lw/sw/addi), 01 sub (beq), 10 use funct, 11 reserved
//  funct      in   6      R-type function code
//  opa        in   WIDTH  operand A (rs)
//  opb        in   WIDTH  operand B (rt/imm); the shifted operand for shifts
//  shamt      in   SW     shift amount
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  result; low half of product for MULTU
//  result_hi  out  WIDTH  high half of product for MULTU; 0 for all other ops
//  zero       out  1      result==0 (and result_hi==0 for MULTU)
//  illegal    out  1      unsupported alu_op/funct; result is 0
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; result, result_hi, zero, illegal=0;
//   iteration counter=0.
//  Decode when alu_op=10:
//   100000 add; 100010 sub; 100100 and; 100101 or; 100111 nor;
//   101010 slt (signed); 101011 sltu; 000000 sll; 000010 srl; 000011 sra; 011001 multu.
//   All other funct values are illegal. alu_op=11 is illegal.
//  add/sub wrap modulo 2^WIDTH; no overflow flag.
//  slt/sltu return {WIDTH-1 zeros, bit}. Shifts apply to opb by shamt.
//  Three states: IDLE, MUL, DONE.
//   in_ready=1 only in IDLE. Accept = in_valid & in_ready; inputs are captured on accept.
//   IDLE, accept of a single-cycle or illegal op:
//    result registered; DONE next cycle. Latency 1 (out_valid the cycle after accept).
//   IDLE, accept of MULTU:
//    multiplicand/multiplier latched; 2*WIDTH accumulator cleared; counter=0; go to MUL.
//   MUL: one multiplier bit per cycle (LSB first). After WIDTH iterations (counter
//    reaches WIDTH-1), load {result_hi,result} and go to DONE.
//    Latency WIDTH+1 cycles from accept to out_valid.
//   DONE: out_valid=1. result, result_hi, zero, illegal are held stable until
//    out_valid & out_ready; then go to IDLE. out_ready low stalls indefinitely.
//    in_valid is ignored while stalled.
//   No overlap: the next request can only be accepted in the cycle after the handshake.
//  Outputs are registered. No combinational path from in_* to out_*.
//  out_valid=0 in IDLE and MUL. The result regs keep their last value but are don't-care.
//  rst asserted mid-MUL or in DONE: immediate abort, all outputs to reset values, the
//   pending result is lost, nothing is emitted after rst deasserts.
//  MUL_EN=0: MULTU is illegal and completes with latency 1.
//  MUL logic may be optimised away.
// TESTING
//  1 alu_op=00, opa=5, opb=7
//    -> out_valid next cycle, result=12, zero=0, illegal=0.
//  2 alu_op=01, opa=opb=0x1234
//    -> result=0, zero=1. funct=101010, opa=0xFFFFFFFF, opb=1 -> result=1.
//    Same with funct=101011 -> result=0.
//  3 funct=000011, opb=0x80000000, shamt=4
//    -> result=0xF8000000. funct=000010 -> 0x08000000.
//  4 funct=011001, opa=0xFFFFFFFF, opb=2
//    -> in_ready=0 for 33 cycles, out_valid on cycle 33, result_hi=1, result=0xFFFFFFFE.
//  5 out_ready=0 for 10 cycles after out_valid
//    -> outputs stable, in_valid pulses ignored. out_ready=1 -> IDLE next cycle.
//  6 rst pulse at iteration 10 of MULTU
//    -> out_valid stays 0, in_ready=1 after reset. Next add works.
//    Also funct=111111 or alu_op=11 -> illegal=1, result=0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALUop/funct and executes behind valid/ready handshakes.
// Single-cycle ops finish in one cycle; MULTU runs as an iterative LSB-first shift-add.
module alu_exec_unit #(
  parameter int unsigned  WIDTH  = 32,
  parameter bit           MUL_EN = 1'b1,
  localparam int unsigned SW     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [SW-1:0]    shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             illegal
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MULTU = 6'b011001;

  logic [1:0]         state;
  logic [SW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               accept;
  logic               is_mul;
  logic               alu_ill;
  logic [WIDTH-1:0]   alu_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign acc_next  = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    is_mul  = 1'b0;
    case (alu_op)
      2'b00: alu_res = opa + opb;
      2'b01: alu_res = opa - opb;
      2'b10: begin
        case (funct)
          F_ADD:   alu_res = opa + opb;
          F_SUB:   alu_res = opa - opb;
          F_AND:   alu_res = opa & opb;
          F_OR:    alu_res = opa | opb;
          F_NOR:   alu_res = ~(opa | opb);
          F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
          F_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (opa < opb)};
          F_SLL:   alu_res = opb << shamt;
          F_SRL:   alu_res = opb >> shamt;
          F_SRA:   alu_res = $unsigned($signed(opb) >>> shamt);
          F_MULTU: begin
            if (MUL_EN) is_mul  = 1'b1;
            else        alu_ill = 1'b1;
          end
          default: alu_ill = 1'b1;
        endcase
      end
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand  <= {{WIDTH{1'b0}}, opa};
              mplier <= opb;
              acc    <= '0;
              count  <= '0;
              state  <= MUL;
            end else begin
              result    <= alu_res;
              result_hi <= '0;
              zero      <= (alu_res == '0);
              illegal   <= alu_ill;
              state     <= DONE;
            end
          end
        end
        MUL: begin
          // Last iteration writes the product straight from acc_next, so WIDTH MUL cycles total.
          if (count == SW'(WIDTH - 1)) begin
            {result_hi, result} <= acc_next;
            zero    <= (acc_next == '0);
            illegal <= 1'b0;
            state   <= DONE;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expectations are queued at issue and popped on out_valid.
module tb_alu_exec_unit;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = '0;
  logic [5:0]  funct = '0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zero;
  logic        illegal;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  alu_exec_unit #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .opa(opa), .opb(opb), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] r, input logic [31:0] h,
                              input logic z, input logic ill);
    exp_t e;
    e.res = r; e.hi = h; e.z = z; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh);
    exp_t e;
    logic [63:0] p;
    e = '0;
    case (op)
      2'b00: e.res = a + b;
      2'b01: e.res = a - b;
      2'b10: begin
        case (fn)
          6'b100000: e.res = a + b;
          6'b100010: e.res = a - b;
          6'b100100: e.res = a & b;
          6'b100101: e.res = a | b;
          6'b100111: e.res = ~(a | b);
          6'b101010: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'b101011: e.res = (a < b) ? 32'd1 : 32'd0;
          6'b000000: e.res = b << sh;
          6'b000010: e.res = b >> sh;
          6'b000011: e.res = $unsigned($signed(b) >>> sh);
          6'b011001: begin
            p = 64'(a) * 64'(b);
            e.res = p[31:0];
            e.hi  = p[63:32];
          end
          default: e.ill = 1'b1;
        endcase
      end
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 32'd0) && (e.hi == 32'd0);
    return e;
  endfunction

  // Drives one request, holds it until accepted, leaves time at accept edge + 1.
  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input exp_t e);
    @(negedge clk);
    alu_op = op; funct = fn; opa = a; opb = b; shamt = sh; in_valid = 1'b1;
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    sb.push_back(e);
  endtask

  // Latency in cycles counted from the accept edge; gives up after 100.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({in_ready, out_valid, result, result_hi, zero, illegal} !== {1'b1, 1'b0, 64'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b res=%h hi=%h z=%b ill=%b, expected rdy=1 vld=0 all else 0",
               in_ready, out_valid, result, result_hi, zero, illegal);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_ops;
    logic [1:0]  ops[7]  = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [5:0]  fns[7]  = '{6'h00, 6'h00, 6'b101010, 6'b101011, 6'b000011, 6'b000010, 6'b000000};
    logic [31:0] as[7]   = '{32'd5, 32'h1234, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
    logic [31:0] bs[7]   = '{32'd7, 32'h1234, 32'd1, 32'd1, 32'h80000000, 32'h80000000, 32'd1};
    logic [4:0]  shs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd4, 5'd31};
    exp_t        exps[7];
    exp_t        e;
    exp_t        act;
    int          lat;
    exps[0] = mk(32'd12, '0, 1'b0, 1'b0);
    exps[1] = mk(32'd0, '0, 1'b1, 1'b0);
    exps[2] = mk(32'd1, '0, 1'b0, 1'b0);
    exps[3] = mk(32'd0, '0, 1'b1, 1'b0);
    exps[4] = mk(32'hF8000000, '0, 1'b0, 1'b0);
    exps[5] = mk(32'h08000000, '0, 1'b0, 1'b0);
    exps[6] = mk(32'h80000000, '0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], fns[i], as[i], bs[i], shs[i], exps[i]);
      wait_out(lat);
      e = sb.pop_front();
      act = {result, result_hi, zero, illegal};
      n_checks++;
      if (lat !== 1) begin
        n_fail++;
        $display("FAIL single_latency[%0d]: got %0d, expected 1", i, lat);
      end
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL single_result[%0d]: got res=%h hi=%h z=%b ill=%b, expected res=%h hi=%h z=%b ill=%b",
                 i, act.res, act.hi, act.z, act.ill, e.res, e.hi, e.z, e.ill);
      end
    end
  endtask

  task automatic test_multu;
    logic [31:0] as[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs[2] = '{32'd2, 32'hFFFFFFFF};
    exp_t        exps[2];
    exp_t        e;
    exp_t        act;
    int          lat;
    exps[0] = mk(32'hFFFFFFFE, 32'd1, 1'b0, 1'b0);
    exps[1] = mk(32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      issue(2'b10, 6'b011001, as[i], bs[i], 5'd0, exps[i]);
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL multu_busy[%0d]: got in_ready=%b, expected 0", i, in_ready);
      end
      wait_out(lat);
      e = sb.pop_front();
      act = {result, result_hi, zero, illegal};
      n_checks++;
      if (lat !== 33) begin
        n_fail++;
        $display("FAIL multu_latency[%0d]: got %0d, expected 33", i, lat);
      end
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL multu_result[%0d]: got res=%h hi=%h z=%b ill=%b, expected res=%h hi=%h z=%b ill=%b",
                 i, act.res, act.hi, act.z, act.ill, e.res, e.hi, e.z, e.ill);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL multu_release[%0d]: got rdy=%b vld=%b, expected rdy=1 vld=0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_stall;
    exp_t e;
    exp_t act;
    int   lat;
    int   bad = 0;
    out_ready = 1'b0;
    issue(2'b00, 6'h00, 32'd3, 32'd4, 5'd0, mk(32'd7, '0, 1'b0, 1'b0));
    wait_out(lat);
    e = sb.pop_front();
    act = {result, result_hi, zero, illegal};
    n_checks++;
    if (act !== e || lat !== 1) begin
      n_fail++;
      $display("FAIL stall_first: got res=%h lat=%0d, expected res=%h lat=1", act.res, lat, e.res);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      alu_op = 2'b01; opa = $urandom; opb = 32'd1;
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {result, result_hi, zero, illegal} !== e) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL stall_hold: got %0d unstable cycles, expected 0", bad);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_abort;
    exp_t e;
    exp_t act;
    int   lat;
    int   seen = 0;
    issue(2'b10, 6'b011001, 32'h12345678, 32'h9ABCDEF0, 5'd0, mk('0, '0, 1'b0, 1'b0));
    void'(sb.pop_back());
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, result, result_hi, zero, illegal} !== {1'b1, 1'b0, 64'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL abort_reset: got rdy=%b vld=%b res=%h hi=%h z=%b ill=%b, expected rdy=1 vld=0 all else 0",
               in_ready, out_valid, result, result_hi, zero, illegal);
    end
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_no_output: got %0d cycles busy or valid, expected 0", seen);
    end
    issue(2'b00, 6'h00, 32'd100, 32'hFFFFFFFF, 5'd0, mk(32'd99, '0, 1'b0, 1'b0));
    wait_out(lat);
    e = sb.pop_front();
    act = {result, result_hi, zero, illegal};
    n_checks++;
    if (act !== e || lat !== 1) begin
      n_fail++;
      $display("FAIL abort_next_add: got res=%h lat=%0d, expected res=%h lat=1", act.res, lat, e.res);
    end
  endtask

  task automatic test_illegal;
    logic [1:0] ops[3] = '{2'b10, 2'b11, 2'b10};
    logic [5:0] fns[3] = '{6'b111111, 6'b100000, 6'b000001};
    exp_t       e;
    exp_t       act;
    int         lat;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], fns[i], 32'hDEADBEEF, 32'h0F0F0F0F, 5'd3, mk('0, '0, 1'b1, 1'b1));
      wait_out(lat);
      e = sb.pop_front();
      act = {result, result_hi, zero, illegal};
      n_checks++;
      if (act !== e || lat !== 1) begin
        n_fail++;
        $display("FAIL illegal[%0d]: got res=%h hi=%h z=%b ill=%b lat=%0d, expected res=0 hi=0 z=1 ill=1 lat=1",
                 i, act.res, act.hi, act.z, act.ill, lat);
      end
    end
  endtask

  task automatic test_random_ops;
    logic [5:0]  fn_tab[12] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010,
                                6'b101011, 6'b000000, 6'b000010, 6'b000011, 6'b011001, 6'b101000};
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    exp_t        e;
    exp_t        act;
    int          lat;
    int          want;
    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom_range(0, 3));
      if (i % 4 == 0) op = 2'b10;
      fn = fn_tab[$urandom_range(0, 11)];
      a  = $urandom;
      b  = (i % 5 == 0) ? a : $urandom;
      sh = 5'($urandom);
      want = (op == 2'b10 && fn == 6'b011001) ? 33 : 1;
      issue(op, fn, a, b, sh, model(op, fn, a, b, sh));
      wait_out(lat);
      e = sb.pop_front();
      act = {result, result_hi, zero, illegal};
      n_checks++;
      if (act !== e || lat !== want) begin
        n_fail++;
        $display("FAIL random[%0d] op=%b fn=%b: got res=%h hi=%h z=%b ill=%b lat=%0d, expected res=%h hi=%h z=%b ill=%b lat=%0d",
                 i, op, fn, act.res, act.hi, act.z, act.ill, lat, e.res, e.hi, e.z, e.ill, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_multu();
    test_stall();
    test_reset_abort();
    test_illegal();
    test_random_ops();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
